rvv_xrf_wb_arbiter: RTL

- Sequences scalar-register (XRF) writebacks from the backend's `NUM_RT_UOP retire slots onto the single async_rd_valid/addr/data/ready port of the RVV core.
- Replaces the "slot 0 only" tie-off.
- Captures one retire group atomically, then drains it strictly in slot order (oldest first), so same-rd writes resolve correctly at the scalar regfile.
- Sits between rvv_backend (rt_xrf_*_rvv2rvs) and the core's async_rd_* outputs.

---
 rtl/rvv_xrf_wb_arbiter_pkg.sv | 13 +
 rtl/rvv_lsb_prio_enc.sv | 30 +++
 rtl/rvv_xrf_wb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rvv_xrf_wb_arbiter_pkg.sv
// Shared constants for the XRF writeback arbiter slice.
// Pure definitions; no logic, no latency, no flow control.
package rvv_xrf_wb_arbiter_pkg;
  localparam int NUM_RT_UOP       = 4;
  localparam int XRF_ADDR_W       = 5;
  localparam int XRF_DATA_W       = 32;
  localparam int STALL_CNT_W_DFLT = 16;

  // Index width that stays legal for a single-slot build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rvv_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant plus binary index.
// Purely combinational, zero latency; no flow control.
// Outputs are all-zero when req is empty.
module rvv_lsb_prio_enc
  import rvv_xrf_wb_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvv_xrf_wb_arbiter.sv
// Serialises one retire group of XRF writebacks onto the single scalar port, oldest slot first.
// Capture at edge N shows on out_valid in cycle N+1; k live slots drain in k cycles.
// A new group is taken only when empty or when the last entry fires; holds steady under !out_ready.
module rvv_xrf_wb_arbiter
  import rvv_xrf_wb_arbiter_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_RT_UOP,
  parameter int ADDR_W      = XRF_ADDR_W,
  parameter int DATA_W      = XRF_DATA_W,
  parameter int STALL_CNT_W = STALL_CNT_W_DFLT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SLOTS-1:0]        in_valid,
  input  logic [NUM_SLOTS*ADDR_W-1:0] in_addr,
  input  logic [NUM_SLOTS*DATA_W-1:0] in_data,
  output logic [NUM_SLOTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  localparam int IW = idx_w(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] pend;
  logic [ADDR_W-1:0]    addr_q [NUM_SLOTS];
  logic [DATA_W-1:0]    data_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] sel_oh;
  logic [IW-1:0]        sel_idx;
  logic [NUM_SLOTS-1:0] cap_mask;
  logic                 fire;
  logic                 last_one;
  logic                 capture;

  rvv_lsb_prio_enc #(.N(NUM_SLOTS)) u_sel (
    .req    (pend),
    .onehot (sel_oh),
    .idx    (sel_idx)
  );

  assign out_valid = |pend;
  assign busy      = out_valid;
  assign fire      = out_valid && out_ready;
  // Exactly one bit pending: the selected grant is the whole mask.
  assign last_one  = out_valid && (pend == sel_oh);
  assign capture   = !rst && (!out_valid || (last_one && fire));
  assign in_ready  = {NUM_SLOTS{capture}};

  assign out_addr  = out_valid ? addr_q[sel_idx] : '0;
  assign out_data  = out_valid ? data_q[sel_idx] : '0;

  // Writes to x0 are accepted but never queued.
  always_comb begin
    cap_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cap_mask[i] = in_valid[i] && (in_addr[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        pend <= cap_mask;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (in_valid[i]) begin
            addr_q[i] <= in_addr[i*ADDR_W +: ADDR_W];
            data_q[i] <= in_data[i*DATA_W +: DATA_W];
          end
        end
      end else if (fire) begin
        pend <= pend & ~sel_oh;
      end

      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

endmodule
